// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and sizes for the hazard controller
package hazard_pkg;

  localparam int unsigned NREG          = 8;
  localparam int unsigned REG_W         = 3;
  localparam int unsigned CNT_W         = 2;
  localparam int unsigned STALL_MAX_DEF = 15;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/scb_cnt.sv
// rtl/scb_cnt.sv - saturating 2-bit in-flight writer count for one register
import hazard_pkg::*;

module scb_cnt (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on issue, down on retire; simultaneous issue+retire cancels,
  // and the count sticks at both ends instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW scoreboard, stall/flush control; HAZARD_CTRL_WATCHDOG_EN adds a stall watchdog
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_srcReg,
  input  logic             ID_srcUse,
  input  logic [REG_W-1:0] ID_writeReg,
  input  logic             ID_RegWrite,
  input  logic             WB_RegWrite,
  input  logic [REG_W-1:0] WB_writeReg,
  input  logic             flush_req,
  output logic             IF_ID_en,
  output logic             IF_ID_kill,
  output logic             ID_EX_bubble,
  output logic             stall,
  output logic [NREG-1:0]  pend,
  output logic             wd_err
);

  if ((STALL_MAX < 1) || (STALL_MAX > 15)) begin : g_stall_max_range
    $error("hazard_ctrl: STALL_MAX must be in 1..15");
  end

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;
  logic [CNT_W-1:0] w_src_cnt;
  logic             w_bypass;
  logic             w_stall;
  logic             w_issue;

  // Hazard detect: a writer is in flight for the source, unless the last one
  // is committing right now (write-first bypass); a flush overrides the stall.
  always_comb begin
    w_src_cnt = w_cnt[ID_srcReg];
    w_bypass  = (w_src_cnt == CNT_W'(1)) && WB_RegWrite && (WB_writeReg == ID_srcReg);
    w_stall   = ID_valid && ID_srcUse && (w_src_cnt != '0) && !w_bypass && !flush_req;
    w_issue   = ID_valid && ID_RegWrite && !w_stall && !flush_req;
  end

  // Per-register issue/retire strobes and pending bitmap.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    pend  = '0;
    for (int i = 0; i < NREG; i++) begin
      w_inc[i] = w_issue && (ID_writeReg == REG_W'(i));
      w_dec[i] = WB_RegWrite && (WB_writeReg == REG_W'(i));
      pend[i]  = (w_cnt[i] != '0);
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_scb
    scb_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_inc[gi]),
      .i_dec (w_dec[gi]),
      .o_cnt (w_cnt[gi])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; flush wins from any state and FLUSH lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_req) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        RUN:     w_state_nxt = w_stall ? STALL : RUN;
        STALL:   w_state_nxt = w_stall ? STALL : RUN;
        FLUSH:   w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign stall        = w_stall;
  assign IF_ID_en     = !w_stall;
  assign IF_ID_kill   = flush_req;
  assign ID_EX_bubble = w_stall || flush_req;

`ifdef HAZARD_CTRL_WATCHDOG_EN
  localparam logic [3:0] WD_LIMIT = 4'(STALL_MAX);

  logic [3:0] r_wd_cnt;
  logic       r_wd_err;

  // Count consecutive cycles spent in STALL; error is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
      r_wd_err <= 1'b0;
    end else if (w_state_nxt == STALL) begin
      if (r_wd_cnt != WD_LIMIT) begin
        r_wd_cnt <= r_wd_cnt + 4'd1;
      end
      if ((r_wd_cnt + 4'd1) == WD_LIMIT) begin
        r_wd_err <= 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign wd_err = r_wd_err;
`else
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl against a scoreboard model
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_WATCHDOG_EN
  localparam int TB_STALL_MAX = 4;
  localparam int WD_ON        = 1;
`else
  localparam int TB_STALL_MAX = 15;
  localparam int WD_ON        = 0;
`endif

  logic       clk;
  logic       rst;
  logic       ID_valid;
  logic [2:0] ID_srcReg;
  logic       ID_srcUse;
  logic [2:0] ID_writeReg;
  logic       ID_RegWrite;
  logic       WB_RegWrite;
  logic [2:0] WB_writeReg;
  logic       flush_req;
  logic       IF_ID_en;
  logic       IF_ID_kill;
  logic       ID_EX_bubble;
  logic       stall;
  logic [7:0] pend;
  logic       wd_err;

  int n_checks;
  int n_errors;

  // reference model: in-flight writers per register, stall streak, sticky watchdog
  int m_cnt [8];
  int m_streak;
  bit m_wd;

  hazard_ctrl #(.STALL_MAX(TB_STALL_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_valid     (ID_valid),
    .ID_srcReg    (ID_srcReg),
    .ID_srcUse    (ID_srcUse),
    .ID_writeReg  (ID_writeReg),
    .ID_RegWrite  (ID_RegWrite),
    .WB_RegWrite  (WB_RegWrite),
    .WB_writeReg  (WB_writeReg),
    .flush_req    (flush_req),
    .IF_ID_en     (IF_ID_en),
    .IF_ID_kill   (IF_ID_kill),
    .ID_EX_bubble (ID_EX_bubble),
    .stall        (stall),
    .pend         (pend),
    .wd_err       (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    p = '0;
    for (int r = 0; r < 8; r++) p[r] = (m_cnt[r] > 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_streak = 0;
    m_wd     = 1'b0;
  endtask

  task automatic idle_inputs();
    ID_valid    = 1'b0;
    ID_srcReg   = '0;
    ID_srcUse   = 1'b0;
    ID_writeReg = '0;
    ID_RegWrite = 1'b0;
    WB_RegWrite = 1'b0;
    WB_writeReg = '0;
    flush_req   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    model_clear();
    #1;
    check("rst_pend", pend, 8'h00);
    check("rst_stall", {7'd0, stall}, 8'h00);
    check("rst_bubble", {7'd0, ID_EX_bubble}, 8'h00);
    check("rst_wd", {7'd0, wd_err}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One ID cycle: drive in the low phase, compare against the model, then
  // advance the model to what the next rising edge must produce.
  task automatic step(input bit v, input int src, input bit use_, input int wr, input bit rw,
                      input bit wbrw, input int wbr, input bit fl);
    bit es;
    bit iss;
    int c;
    @(negedge clk);
    ID_valid    = v;
    ID_srcReg   = 3'(src);
    ID_srcUse   = use_;
    ID_writeReg = 3'(wr);
    ID_RegWrite = rw;
    WB_RegWrite = wbrw;
    WB_writeReg = 3'(wbr);
    flush_req   = fl;
    #1;
    c  = m_cnt[src];
    es = v && use_ && (c != 0) && !(c == 1 && wbrw && wbr == src) && !fl;
    check("stall", {7'd0, stall}, {7'd0, es});
    check("if_id_en", {7'd0, IF_ID_en}, {7'd0, !es});
    check("if_id_kill", {7'd0, IF_ID_kill}, {7'd0, fl});
    check("id_ex_bubble", {7'd0, ID_EX_bubble}, {7'd0, es || fl});
    check("pend", pend, model_pend());
    check("wd_err", {7'd0, wd_err}, {7'd0, m_wd});
    iss = v && rw && !es && !fl;
    for (int r = 0; r < 8; r++) begin
      c = m_cnt[r] + ((iss && wr == r) ? 1 : 0) - ((wbrw && wbr == r) ? 1 : 0);
      if (c > 3) c = 3;
      if (c < 0) c = 0;
      m_cnt[r] = c;
    end
    m_streak = es ? m_streak + 1 : 0;
    if (WD_ON != 0 && m_streak >= TB_STALL_MAX) m_wd = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle_inputs();
    model_clear();
    do_reset();

    // write r3, then read r3 until it commits; bypass in the WB cycle
    step(1, 0, 0, 3, 1, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0);
    check("r3_stall_a", {7'd0, stall}, 8'h01);
    step(1, 3, 1, 0, 0, 0, 0, 0);
    check("r3_en_b", {7'd0, IF_ID_en}, 8'h00);
    step(1, 3, 1, 0, 0, 1, 3, 0);
    check("r3_bypass", {7'd0, stall}, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("r3_pend_clear", pend, 8'h00);

    // two writes to r5, stall persists through the first WB
    step(1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 1, 5, 0);
    check("r5_first_wb", {7'd0, stall}, 8'h01);
    step(1, 5, 1, 0, 0, 1, 5, 0);
    check("r5_second_wb", {7'd0, stall}, 8'h00);

    // stall on r2 overridden by flush; flushed writer must not issue
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 2, 1, 4, 1, 0, 0, 1);
    check("flush_kill", {7'd0, IF_ID_kill}, 8'h01);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_no_issue", pend, 8'h04);
    step(0, 0, 0, 0, 0, 1, 2, 0);

    // issue and retire r1 together at count 1
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("r1_hold", pend, 8'h02);
    step(0, 0, 0, 0, 0, 1, 1, 0);

    // saturation at 3: four issues, three retires clear the register
    for (int k = 0; k < 4; k++) step(1, 0, 0, 6, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1, 6, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("sat_clear", pend, 8'h00);

    // watchdog: hold a hazard long enough, error stays after release
    step(1, 0, 0, 4, 1, 0, 0, 0);
    for (int k = 0; k < TB_STALL_MAX; k++) step(1, 4, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("wd_sticky", {7'd0, wd_err}, WD_ON != 0 ? 8'h01 : 8'h00);

    // asynchronous reset in the middle of a stall with r2 and r5 pending
    do_reset();
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    ID_valid  = 1'b1;
    ID_srcReg = 3'd2;
    ID_srcUse = 1'b1;
    ID_RegWrite = 1'b0;
    #1;
    check("mid_pend", pend, 8'h24);
    check("mid_stall", {7'd0, stall}, 8'h01);
    #1;
    rst = 1'b0;
    #1;
    check("async_pend", pend, 8'h00);
    check("async_stall", {7'd0, stall}, 8'h00);
    model_clear();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // randomized traffic over a narrow register set to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0));
      if (n == 1000) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter STALL_MAX, default 15, SHALL set the watchdog limit in consecutive stall cycles (4-bit range, 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 ID_valid  input  1  an instruction is present in ID.
REQ-005 ID_srcReg  input  3  source register read by the ID instruction.
REQ-006 ID_srcUse  input  1  the ID instruction actually reads ID_srcReg.
REQ-007 ID_writeReg  input  3  destination register of the ID instruction.
REQ-008 ID_RegWrite  input  1  the ID instruction writes ID_writeReg.
REQ-009 WB_RegWrite  input  1  writeback is committing this cycle.
REQ-010 WB_writeReg  input  3  register being committed.
REQ-011 flush_req  input  1  taken branch/redirect raised from EX.
REQ-012 IF_ID_en  output  1  IF/ID register load enable.
REQ-013 IF_ID_kill  output  1  IF/ID register loads a NOP.
REQ-014 ID_EX_bubble  output  1  ID/EX register loads zeros (bubble).
REQ-015 stall  output  1  a RAW hazard holds ID this cycle.
REQ-016 pend  output  8  bit i = register i has at least one in-flight writer.
REQ-017 wd_err  output  1  sticky watchdog error (only when REQ-030 is enabled).

Function
REQ-018 Scoreboard: one 2-bit in-flight count per register, 8 counts in total; pend[i] = (count[i] != 0).
REQ-019 Issue: when ID_valid & ID_RegWrite & !stall & !flush_req, count[ID_writeReg] SHALL increment on the next edge.
REQ-020 Retire: when WB_RegWrite is high, count[WB_writeReg] SHALL decrement on the next edge.
REQ-021 Issue and retire to the same register in one cycle SHALL leave its count unchanged.
REQ-022 The count SHALL saturate at 3 and at 0; an increment at 3 or a decrement at 0 is ignored.
REQ-023 stall = ID_valid & ID_srcUse & (count[ID_srcReg] != 0) & !(count[ID_srcReg] == 1 & WB_RegWrite & WB_writeReg == ID_srcReg) & !flush_req.
- This gives write-first bypass from WB.
REQ-024 The FSM SHALL have states RUN, STALL and FLUSH.
- RUN->STALL when stall is high.
- STALL->RUN when stall is low.
- Any state->FLUSH when flush_req is high.
- FLUSH->RUN after exactly one cycle, unless flush_req is high again.
REQ-025 Outputs SHALL be combinational from the current inputs and state:
- IF_ID_en = !stall.
- IF_ID_kill = flush_req.
- ID_EX_bubble = stall | flush_req.
REQ-026 flush_req SHALL have priority over stall; a flushed ID instruction SHALL NOT issue (REQ-019).
REQ-027 Instructions already in EX/WB when flush_req is high SHALL still retire normally.
REQ-028 An 8-bit wrap of register indices is not applicable; indices are 3-bit and exact.

Reset
REQ-029 While rst=0 the block SHALL hold all counts at 0, state = RUN, the stall counter at 0 and wd_err = 0.
- Consequently pend = 0.
- stall, IF_ID_kill and ID_EX_bubble SHALL be 0 for ID_valid=0.
- Reset mid-stall SHALL discard all pending writers immediately.

Configuration
REQ-030 With HAZARD_CTRL_WATCHDOG_EN defined:
- A 4-bit counter SHALL count consecutive cycles in STALL and clear on leaving STALL.
- When the counter reaches STALL_MAX, wd_err SHALL set and stay set until reset.
- Without the macro, no counter is built and wd_err SHALL be tied to 0.

Structure
REQ-031 Package hazard_pkg SHALL hold:
- the FSM state typedef (RUN/STALL/FLUSH);
- NREG=8;
- REG_W=3;
- CNT_W=2;
- the default STALL_MAX.
REQ-032 The per-register saturating up/down counter SHALL be a sub-module, scb_cnt, instantiated NREG times.

Verification
REQ-033 Reset, then issue a write to r3 and read r3 in the next ID cycle -> stall=1, ID_EX_bubble=1, IF_ID_en=0 until the r3 WB cycle; in the WB cycle stall=0 (bypass).
REQ-034 Two back-to-back writes to r5, then a read of r5 -> count reaches 2; stall persists through the first WB and releases in the second WB cycle.
REQ-035 Stall on r2 with flush_req=1 in the same cycle -> stall=0, IF_ID_kill=1, ID_EX_bubble=1; the flushed writer does not increment its count.
REQ-036 Issue to r1 with a simultaneous WB of r1 at count 1 -> count stays 1, pend[1]=1.
REQ-037 Assert rst=0 mid-stall with pend=8'h24 -> pend=0, stall=0 and state=RUN asynchronously.
REQ-038 With HAZARD_CTRL_WATCHDOG_EN and STALL_MAX=4, hold a hazard for 4 cycles -> wd_err=1 and it stays set after the stall clears.
